// File: rtl/sortn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sortn_pipe
// Purpose  : Pipelined odd-even transposition sorter. Each beat carries
//            NUM_ELEMS unsigned elements of DATA_WIDTH bits and is emitted
//            sorted ascending or descending (per-beat in_desc) after
//            NUM_ELEMS register stages. The sort is stable.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            in_valid/in_ready/in_data/in_desc   - input beat handshake
//            out_valid/out_ready/out_data        - output beat handshake
//            out_idx        - original index of each output element
//                             (present only when SORTN_INDEX_EN is defined)
// Options  : SORTN_INDEX_EN - carry IDX_W-bit position tags with the data
// Revision : 1.0 - initial release
// ============================================================================
module sortn_pipe #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  in_data,
  input  logic                             in_desc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0]  out_data
`ifdef SORTN_INDEX_EN
 ,output logic [NUM_ELEMS*$clog2(NUM_ELEMS)-1:0] out_idx
`endif
);

  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam int VEC_W = NUM_ELEMS * DATA_WIDTH;

  // Stage registers. Stage s holds the result of compare-swap layer s.
  logic [VEC_W-1:0]     data_q [NUM_ELEMS];
  logic [VEC_W-1:0]     data_d [NUM_ELEMS];
  logic [NUM_ELEMS-1:0] valid_q;
  // The final stage feeds no further compare layer, so its direction bit
  // would be dead; only stages 0..NUM_ELEMS-2 keep one.
  logic [NUM_ELEMS-2:0] desc_q;

  // Per-stage inputs: stage 0 takes the input port, stage s takes stage s-1.
  logic [VEC_W-1:0]     w_src_data [NUM_ELEMS];
  logic [NUM_ELEMS-1:0] w_src_desc;
  logic [NUM_ELEMS-1:0] w_src_valid;
  logic                 w_adv;

`ifdef SORTN_INDEX_EN
  logic [NUM_ELEMS*IDX_W-1:0] idx_q     [NUM_ELEMS];
  logic [NUM_ELEMS*IDX_W-1:0] idx_d     [NUM_ELEMS];
  logic [NUM_ELEMS*IDX_W-1:0] w_src_idx [NUM_ELEMS];
`endif

  // Global stall: the whole pipe moves only when the output slot is free
  // or being drained this cycle.
  assign w_adv     = !valid_q[NUM_ELEMS-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = valid_q[NUM_ELEMS-1];
  assign out_data  = data_q[NUM_ELEMS-1];
`ifdef SORTN_INDEX_EN
  assign out_idx   = idx_q[NUM_ELEMS-1];
`endif

  // Source selection for each stage.
  always_comb begin
    w_src_data[0]  = in_data;
    w_src_desc[0]  = in_desc;
    w_src_valid[0] = in_valid;
`ifdef SORTN_INDEX_EN
    w_src_idx[0] = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      w_src_idx[0][i*IDX_W +: IDX_W] = IDX_W'(i);
    end
`endif
    for (int s = 1; s < NUM_ELEMS; s++) begin
      w_src_data[s]  = data_q[s-1];
      w_src_desc[s]  = desc_q[s-1];
      w_src_valid[s] = valid_q[s-1];
`ifdef SORTN_INDEX_EN
      w_src_idx[s] = idx_q[s-1];
`endif
    end
  end

  // Compare-swap layers: even stages pair (0,1),(2,3)...; odd stages pair
  // (1,2),(3,4)...; an unpaired element passes straight through. Strict
  // comparison keeps equal elements in input order.
  always_comb begin
    for (int s = 0; s < NUM_ELEMS; s++) begin
      data_d[s] = w_src_data[s];
`ifdef SORTN_INDEX_EN
      idx_d[s] = w_src_idx[s];
`endif
      for (int p = s % 2; p + 1 < NUM_ELEMS; p = p + 2) begin
        if (w_src_desc[s] ? (w_src_data[s][p*DATA_WIDTH +: DATA_WIDTH] <
                             w_src_data[s][(p+1)*DATA_WIDTH +: DATA_WIDTH])
                          : (w_src_data[s][p*DATA_WIDTH +: DATA_WIDTH] >
                             w_src_data[s][(p+1)*DATA_WIDTH +: DATA_WIDTH])) begin
          data_d[s][p*DATA_WIDTH +: DATA_WIDTH]     = w_src_data[s][(p+1)*DATA_WIDTH +: DATA_WIDTH];
          data_d[s][(p+1)*DATA_WIDTH +: DATA_WIDTH] = w_src_data[s][p*DATA_WIDTH +: DATA_WIDTH];
`ifdef SORTN_INDEX_EN
          idx_d[s][p*IDX_W +: IDX_W]     = w_src_idx[s][(p+1)*IDX_W +: IDX_W];
          idx_d[s][(p+1)*IDX_W +: IDX_W] = w_src_idx[s][p*IDX_W +: IDX_W];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      desc_q  <= '0;
      for (int s = 0; s < NUM_ELEMS; s++) begin
        data_q[s] <= '0;
`ifdef SORTN_INDEX_EN
        idx_q[s] <= '0;
`endif
      end
    end else if (w_adv) begin
      valid_q <= w_src_valid;
      desc_q  <= w_src_desc[NUM_ELEMS-2:0];
      for (int s = 0; s < NUM_ELEMS; s++) begin
        data_q[s] <= data_d[s];
`ifdef SORTN_INDEX_EN
        idx_q[s] <= idx_d[s];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sortn_pipe.md
# sortn_pipe

Parametrised, pipelined sorter: accepts a packed vector of `NUM_ELEMS` unsigned elements per beat and emits the same elements sorted ascending or descending after a fixed latency. It generalises the fixed 4-element sorter to any element count and width, with a valid/ready handshake, per-beat sort direction, full throughput, and backpressure. It sits between a data producer and any consumer that needs ordered vectors, such as a median filter or top-k selector.

## Interface
- `DATA_WIDTH`, 3: bits per unsigned element, ≥1.
- `NUM_ELEMS`, 4: elements per vector, ≥2; any integer value is allowed.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  sorter can accept a beat this cycle.
- `in_data`  in  `NUM_ELEMS*DATA_WIDTH`  element i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_desc`  in  1  0 = ascending (element 0 smallest), 1 = descending; sampled with the beat.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `NUM_ELEMS*DATA_WIDTH`  sorted vector, same packing as `in_data`.
- `out_idx`  out  `NUM_ELEMS*IDX_W`  original index of each output element, where `IDX_W = $clog2(NUM_ELEMS)`. Present only with `SORTN_INDEX_EN`.

## Operation
- Odd-even transposition network of `NUM_ELEMS` register stages, numbered s = 0..NUM_ELEMS-1.
  - Even stages compare-swap pairs (0,1), (2,3), …
  - Odd stages compare-swap pairs (1,2), (3,4), …
  - With odd `NUM_ELEMS`, any unpaired element passes through unchanged.
- Swap rule:
  - Ascending: swap when lower-index > higher-index (strict).
  - Descending: swap when lower-index < higher-index (strict).
  - Because the comparison is strict, equal elements keep their input order, so the sort is stable.
- Each stage register holds the data vector, a desc bit, a valid bit, and (with `SORTN_INDEX_EN`) the index tags.
- The desc bit travels with the beat, so consecutive beats may use different directions.
- Comparisons are unsigned over the full `DATA_WIDTH`. No widening or truncation occurs.
- Flow control uses a global stall:
  - `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - All stages shift only when `adv` is 1.
  - A beat is accepted when `in_valid && in_ready`.
  - When `adv` is 1 and `in_valid` is 0, a bubble (valid = 0) enters stage 0.
- While stalled (`out_valid && !out_ready`), every stage register holds its value and `in_ready` is 0.

## Timing
- Reset values, applied asynchronously while `rst` is 1:
  - All stage valid bits are 0.
  - All data, desc bits and index tags are 0.
  - `out_valid = 0`, `out_data = 0`, `out_idx = 0`, `in_ready = 1`.
- Latency: a beat accepted on edge k appears on `out_valid`/`out_data` after edge k+NUM_ELEMS-1, i.e. it is visible for the first time in cycle k+NUM_ELEMS, provided no stall occurs.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Outputs are registered and come from the last stage. No input-to-output combinational path exists except `out_ready` → `in_ready`.
- Simultaneous accept at the input and pop at the output in the same cycle is legal and loses no data.
- Asserting `rst` mid-operation discards all in-flight beats. `out_valid` falls to 0 immediately, without waiting for a clock edge.
- Releasing `rst` is synchronised externally. The first beat may be accepted on the first edge after release.

## Configuration
- `SORTN_INDEX_EN` defined:
  - Each element carries an `IDX_W`-bit tag, initialised to its input position i, and the tag is swapped with its element.
  - `out_idx` presents the resulting permutation.
- `SORTN_INDEX_EN` undefined:
  - The `out_idx` port and all tag registers are absent.
  - Sorting behaviour is otherwise identical.

## Test plan
All scenarios use `DATA_WIDTH=3`, `NUM_ELEMS=4`. Vectors are listed as element 0..3.

1. Reset then single beat: in {5,1,7,3}, desc=0, `out_ready`=1 → exactly 4 cycles later `out_valid`=1, out {1,3,5,7}, `out_idx` {1,3,0,2}; `out_valid`=0 on all other cycles.
2. Back-to-back beats with alternating direction: {5,1,7,3} desc=1, then {0,7,0,7} desc=0, then {2,2,2,2} desc=0 → consecutive outputs {7,5,3,1}, {0,0,7,7} with `out_idx` {0,2,1,3}, then {2,2,2,2} with `out_idx` {0,1,2,3} (stability).
3. Backpressure: stream 8 beats while driving `out_ready` low for 3 cycles mid-stream → `in_ready` drops the same cycle, `out_data` holds steady, and all 8 sorted beats arrive in order with none lost or duplicated.
4. Reset mid-flight: accept 3 beats, assert `rst` before any output appears → `out_valid`=0 at once; after release no stale beat emerges and a fresh beat {3,2,1,0} yields {0,1,2,3}.
5. Random regression: 1000 random vectors with random direction and random `out_ready` → every output matches a stable reference sort and the beat count in equals the beat count out.
